// File: rtl/kanagawa_fifo_error_reporter.sv
// kanagawa_fifo_error_reporter
//   Watches sticky overflow/underflow flags from NUM_FIFOS FIFO debug monitors.
//   It reports each new assertion of a flag exactly once, on a valid/ready
//   stream with one FIFO per report. Reports are scheduled round-robin,
//   starting from the FIFO after the last one granted. The block also keeps a
//   saturating count of reported flags and a registered any-error summary.
//
// Ports
//   clk                   single clock
//   rst                   synchronous, active-high reset
//   overflow_in           sticky overflow flag per FIFO
//   underflow_in          sticky underflow flag per FIFO
//   clear_in              pulse: zero error_count_out (wins over an increment)
//   report_valid_out      report payload valid
//   report_ready_in       consumer accepts report
//   report_index_out      FIFO index being reported
//   report_overflow_out   report includes overflow
//   report_underflow_out  report includes underflow
//   any_error_out         registered OR of all input flags
//   error_count_out       number of reported flags, saturating
module kanagawa_fifo_error_reporter #(
   parameter int NUM_FIFOS   = 8,
   parameter int COUNT_WIDTH = 16,
   localparam int IDX_W      = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_FIFOS-1:0]   overflow_in,
   input  logic [NUM_FIFOS-1:0]   underflow_in,
   input  logic                   clear_in,
   output logic                   report_valid_out,
   input  logic                   report_ready_in,
   output logic [IDX_W-1:0]       report_index_out,
   output logic                   report_overflow_out,
   output logic                   report_underflow_out,
   output logic                   any_error_out,
   output logic [COUNT_WIDTH-1:0] error_count_out
);

   typedef enum logic {IDLE, PRESENT} state_t;

   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

   state_t                 state_reg, state_next;
   logic [IDX_W-1:0]       last_grant_reg, last_grant_next;
   logic [IDX_W-1:0]       idx_reg, idx_next;
   logic                   lat_ovf_reg, lat_ovf_next;
   logic                   lat_unf_reg, lat_unf_next;
   logic [NUM_FIFOS-1:0]   ovf_rep_reg, ovf_rep_next;
   logic [NUM_FIFOS-1:0]   unf_rep_reg, unf_rep_next;
   logic [COUNT_WIDTH-1:0] count_reg, count_next;
   logic                   any_err_reg;

   logic [NUM_FIFOS-1:0]   pending;
   logic [NUM_FIFOS-1:0]   ovf_pend;
   logic [NUM_FIFOS-1:0]   unf_pend;
   logic [NUM_FIFOS-1:0]   hs_sel;
   logic                   handshake;
   logic                   grant_found;
   logic [IDX_W-1:0]       grant_idx;
   int                     cand;
   logic [COUNT_WIDTH+1:0] count_sum;

   assign handshake = (state_reg == PRESENT) && report_ready_in;

   // Per-FIFO pending detection and report masks. A mask bit is set when the
   // matching report is accepted. It follows its input down, so a flag that
   // falls and rises again is reported again. This is true even when the
   // flag falls while its report is still waiting for the handshake.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_FIFOS; gi++) begin : g_fifo
         assign ovf_pend[gi]     = overflow_in[gi]  & ~ovf_rep_reg[gi];
         assign unf_pend[gi]     = underflow_in[gi] & ~unf_rep_reg[gi];
         assign pending[gi]      = ovf_pend[gi] | unf_pend[gi];
         assign hs_sel[gi]       = handshake && (idx_reg == IDX_W'(gi));
         assign ovf_rep_next[gi] = (ovf_rep_reg[gi] | (hs_sel[gi] & lat_ovf_reg)) & overflow_in[gi];
         assign unf_rep_next[gi] = (unf_rep_reg[gi] | (hs_sel[gi] & lat_unf_reg)) & underflow_in[gi];
      end
   endgenerate

   // Round-robin search. Start one past the last grant and wrap modulo NUM_FIFOS.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = 1; k <= NUM_FIFOS; k++) begin
         cand = (int'(last_grant_reg) + k) % NUM_FIFOS;
         if (!grant_found && pending[cand]) begin
            grant_found = 1'b1;
            grant_idx   = IDX_W'(cand);
         end
      end
   end

   // FSM next state. The payload is latched on a grant and then held until the handshake.
   always_comb begin
      state_next      = state_reg;
      idx_next        = idx_reg;
      lat_ovf_next    = lat_ovf_reg;
      lat_unf_next    = lat_unf_reg;
      last_grant_next = last_grant_reg;
      case (state_reg)
         IDLE: begin
            if (grant_found) begin
               state_next   = PRESENT;
               idx_next     = grant_idx;
               lat_ovf_next = ovf_pend[grant_idx];
               lat_unf_next = unf_pend[grant_idx];
            end
         end
         PRESENT: begin
            if (report_ready_in) begin
               state_next      = IDLE;
               last_grant_next = idx_reg;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Saturating counter. A clear has priority over an increment in the same cycle.
   always_comb begin
      count_sum  = (COUNT_WIDTH+2)'(count_reg) + (COUNT_WIDTH+2)'(lat_ovf_reg)
                 + (COUNT_WIDTH+2)'(lat_unf_reg);
      count_next = count_reg;
      if (clear_in) begin
         count_next = '0;
      end else if (handshake) begin
         if (count_sum > (COUNT_WIDTH+2)'(COUNT_MAX)) begin
            count_next = COUNT_MAX;
         end else begin
            count_next = count_sum[COUNT_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         last_grant_reg <= IDX_W'(NUM_FIFOS - 1);
         idx_reg        <= '0;
         lat_ovf_reg    <= 1'b0;
         lat_unf_reg    <= 1'b0;
         ovf_rep_reg    <= '0;
         unf_rep_reg    <= '0;
         count_reg      <= '0;
         any_err_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         idx_reg        <= idx_next;
         lat_ovf_reg    <= lat_ovf_next;
         lat_unf_reg    <= lat_unf_next;
         ovf_rep_reg    <= ovf_rep_next;
         unf_rep_reg    <= unf_rep_next;
         count_reg      <= count_next;
         any_err_reg    <= |(overflow_in | underflow_in);
      end
   end

   assign report_valid_out     = (state_reg == PRESENT);
   assign report_index_out     = idx_reg;
   assign report_overflow_out  = lat_ovf_reg;
   assign report_underflow_out = lat_unf_reg;
   assign any_error_out        = any_err_reg;
   assign error_count_out      = count_reg;

endmodule

// File: tb/tb_kanagawa_fifo_error_reporter.sv
// Testbench for kanagawa_fifo_error_reporter.
// The driver applies inputs 1 time unit after each rising edge. It advances a
// behavioural model that predicts what the DUT does on the next edge. Each
// report the model grants goes into a scoreboard queue. The monitor samples
// on the falling edge. It checks valid, count and any_error against the model.
// It also checks each presented payload against the queue head, and pops the
// head on a handshake.
module tb_kanagawa_fifo_error_reporter;
   localparam int N    = 8;
   localparam int CW   = 4;
   localparam int IW   = 3;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct {
      int idx;
      bit o;
      bit u;
   } rep_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  ovf;
   logic [N-1:0]  unf;
   logic          clr;
   logic          ready;
   logic          valid;
   logic [IW-1:0] idx;
   logic          r_ovf;
   logic          r_unf;
   logic          any_err;
   logic [CW-1:0] count;

   kanagawa_fifo_error_reporter #(.NUM_FIFOS(N), .COUNT_WIDTH(CW)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .overflow_in          (ovf),
      .underflow_in         (unf),
      .clear_in             (clr),
      .report_valid_out     (valid),
      .report_ready_in      (ready),
      .report_index_out     (idx),
      .report_overflow_out  (r_ovf),
      .report_underflow_out (r_unf),
      .any_error_out        (any_err),
      .error_count_out      (count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int n_rep = 0;

   // Model state: the reported-flag sets, the report in flight, and the running count.
   bit   m_orep[N];
   bit   m_urep[N];
   bit   m_pres;
   rep_t m_cur;
   int   m_cnt;
   int   m_last;
   bit   m_any;
   rep_t sb_q[$];

   // Expected values after the most recent edge, used by the monitor.
   bit exp_valid;
   int exp_cnt;
   bit exp_any;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Predict the effect of the upcoming clock edge, given the inputs now applied.
   task automatic model_step();
      bit   hs;
      bit   new_o[N];
      bit   new_u[N];
      rep_t r;
      if (rst) begin
         if (m_pres) void'(sb_q.pop_back());
         foreach (m_orep[i]) begin
            m_orep[i] = 0;
            m_urep[i] = 0;
         end
         m_pres = 0;
         m_cnt  = 0;
         m_last = N - 1;
         m_any  = 0;
         return;
      end
      hs    = m_pres && ready;
      m_any = |(ovf | unf);
      if (clr) begin
         m_cnt = 0;
      end else if (hs) begin
         m_cnt = m_cnt + m_cur.o + m_cur.u;
         if (m_cnt > CMAX) m_cnt = CMAX;
      end
      for (int i = 0; i < N; i++) begin
         new_o[i] = (m_orep[i] || (hs && m_cur.idx == i && m_cur.o)) && ovf[i];
         new_u[i] = (m_urep[i] || (hs && m_cur.idx == i && m_cur.u)) && unf[i];
      end
      if (hs) begin
         m_last = m_cur.idx;
         m_pres = 0;
      end else if (!m_pres) begin
         for (int k = 1; k <= N; k++) begin
            int j;
            j   = (m_last + k) % N;
            r.idx = j;
            r.o = ovf[j] && !m_orep[j];
            r.u = unf[j] && !m_urep[j];
            if (r.o || r.u) begin
               m_pres = 1;
               m_cur  = r;
               sb_q.push_back(r);
               break;
            end
         end
      end
      m_orep = new_o;
      m_urep = new_u;
   endtask

   task automatic drive(input logic [N-1:0] o, input logic [N-1:0] u,
                        input logic rd, input logic cl, input logic rs);
      @(posedge clk);
      #1;
      exp_valid = m_pres;
      exp_cnt   = m_cnt;
      exp_any   = m_any;
      chk_en    = 1'b1;
      ovf   = o;
      unf   = u;
      ready = rd;
      clr   = cl;
      rst   = rs;
      model_step();
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("valid", int'(valid), int'(exp_valid));
         chk("count", int'(count), exp_cnt);
         chk("any_error", int'(any_err), int'(exp_any));
         if (valid && !rst) begin
            if (sb_q.size() == 0) begin
               chk("sb_nonempty", 0, 1);
            end else begin
               chk("rep_index", int'(idx), sb_q[0].idx);
               chk("rep_ovf", int'(r_ovf), int'(sb_q[0].o));
               chk("rep_unf", int'(r_unf), int'(sb_q[0].u));
               if (ready) begin
                  $display("report %0d: idx=%0d ovf=%0b unf=%0b count_before=%0d",
                           n_rep, idx, r_ovf, r_unf, count);
                  n_rep++;
                  void'(sb_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      logic [N-1:0] o;
      logic [N-1:0] u;
      rst = 1'b1; ovf = '0; unf = '0; clr = 1'b0; ready = 1'b0;
      model_step();
      repeat (3) drive('0, '0, 1'b0, 1'b0, 1'b1);
      // 1: single overflow held high
      repeat (8) drive(8'h08, '0, 1'b1, 1'b0, 1'b0);
      drive('0, '0, 1'b1, 1'b0, 1'b0);
      // 2: simultaneous flags, then round-robin ordering from the last grant
      repeat (8) drive(8'h21, 8'h20, 1'b1, 1'b0, 1'b0);
      drive('0, '0, 1'b1, 1'b1, 1'b0);
      repeat (8) drive(8'h44, '0, 1'b1, 1'b0, 1'b0);
      drive('0, '0, 1'b1, 1'b1, 1'b0);
      // 3: stalled report with its flag dropping mid-wait
      repeat (5) drive(8'h10, '0, 1'b0, 1'b0, 1'b0);
      repeat (5) drive('0, '0, 1'b0, 1'b0, 1'b0);
      repeat (3) drive('0, '0, 1'b1, 1'b0, 1'b0);
      // 4: underflow re-assertion is reported again
      repeat (4) drive('0, 8'h02, 1'b1, 1'b0, 1'b0);
      drive('0, '0, 1'b1, 1'b0, 1'b0);
      repeat (4) drive('0, 8'h02, 1'b1, 1'b0, 1'b0);
      drive('0, '0, 1'b1, 1'b0, 1'b0);
      // 5: saturation, then a clear coincident with a handshake
      for (int n = 0; n < 20; n++) begin
         o = 8'(1 << (n % N));
         repeat (3) drive(o, o, 1'b1, 1'b0, 1'b0);
         drive('0, '0, 1'b1, 1'b0, 1'b0);
      end
      repeat (3) drive(8'h80, '0, 1'b0, 1'b0, 1'b0);
      drive(8'h80, '0, 1'b1, 1'b1, 1'b0);
      repeat (2) drive(8'h80, '0, 1'b1, 1'b0, 1'b0);
      drive('0, '0, 1'b1, 1'b1, 1'b0);
      // 6: reset during a stalled report, then reissue
      repeat (3) drive(8'h20, '0, 1'b0, 1'b0, 1'b0);
      drive(8'h20, '0, 1'b0, 1'b0, 1'b1);
      repeat (2) drive(8'h20, '0, 1'b0, 1'b0, 1'b0);
      repeat (3) drive(8'h20, '0, 1'b1, 1'b0, 1'b0);
      // Randomised phase: flags flip occasionally, ready is random, rare clear/reset
      o = '0;
      u = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 15) == 0) o[i] = ~o[i];
            if ($urandom_range(0, 15) == 0) u[i] = ~u[i];
         end
         drive(o, u, ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0),
               ($urandom_range(0, 199) == 0));
      end
      repeat (2) drive('0, '0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
